lock_key_loader: RTL and testbench

//  Serial key loader that drives the 4-bit mux-lock key (p1..p4) of the locked c499 corrector.

---
 rtl/lock_key_loader_if.sv | 52 +++++
 rtl/lock_key_loader.sv | 154 +++++++++++++++
 tb/tb_lock_key_loader.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_key_loader_if.sv
// -----------------------------------------------------------------------------
// lock_key_loader_if
// Bundles the serial key-load bus of lock_key_loader.
//   master : key source (drives key_sen/key_sdi/key_load[/zeroize], sees status)
//   slave  : the loader itself
// Signals
//   key_sen   shift enable, key_sdi sampled when high
//   key_sdi   serial key data, LSB first, even parity bit last
//   key_load  commit request, 1-cycle pulse
//   key_out   key to the corrector: [0]=p1 [1]=p2 [2]=p3 [3]=p4
//   key_valid key_out holds a committed key
//   load_done 1-cycle pulse on successful commit
//   load_err  1-cycle pulse on failed commit
//   fail_cnt  failed commits since reset, saturating
//   locked    loader is in lockout
//   zeroize   (only with KEY_ZEROIZE_EN) clears the held key
// -----------------------------------------------------------------------------
interface lock_key_loader_if #(
   parameter int unsigned KEY_W  = 4,
   parameter int unsigned FAIL_W = 2
);
   logic              key_sen;
   logic              key_sdi;
   logic              key_load;
   logic [KEY_W-1:0]  key_out;
   logic              key_valid;
   logic              load_done;
   logic              load_err;
   logic [FAIL_W-1:0] fail_cnt;
   logic              locked;
`ifdef KEY_ZEROIZE_EN
   logic              zeroize;

   modport master (
      output key_sen, key_sdi, key_load, zeroize,
      input  key_out, key_valid, load_done, load_err, fail_cnt, locked
   );
   modport slave (
      input  key_sen, key_sdi, key_load, zeroize,
      output key_out, key_valid, load_done, load_err, fail_cnt, locked
   );
`else
   modport master (
      output key_sen, key_sdi, key_load,
      input  key_out, key_valid, load_done, load_err, fail_cnt, locked
   );
   modport slave (
      input  key_sen, key_sdi, key_load,
      output key_out, key_valid, load_done, load_err, fail_cnt, locked
   );
`endif
endinterface

// File: rtl/lock_key_loader.sv
// -----------------------------------------------------------------------------
// lock_key_loader
// Serial loader for the 4-bit mux-lock key (p1..p4) of the locked c499
// corrector. A frame of KEY_W key bits plus one even-parity bit is shifted in
// LSB first; key_load commits it only if exactly FRAME_W bits arrived and the
// parity holds. Until a commit succeeds, and after any failed commit, key_out
// carries DECOY. MAX_FAIL failed commits lock the loader out until reset.
//
// Ports
//   clk    in  rising-edge clock
//   rst_n  in  synchronous reset, active-low
//   bus    lock_key_loader_if.slave (see interface file for signal list)
//
// Optional feature macro: KEY_ZEROIZE_EN
//   Adds bus.zeroize: clears the held key and any partial frame and returns to
//   IDLE, in every state except LOCKOUT. fail_cnt is kept, no pulse is issued.
// -----------------------------------------------------------------------------
module lock_key_loader #(
   parameter int unsigned      KEY_W    = 4,
   parameter logic [KEY_W-1:0] DECOY    = '0,
   parameter int unsigned      MAX_FAIL = 3,
   parameter int unsigned      FAIL_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   lock_key_loader_if.slave  bus
);

   localparam int unsigned FRAME_W  = KEY_W + 1;
   // bit_cnt must reach FRAME_W+1 to remember an overflowed frame.
   localparam int unsigned CNT_W    = $clog2(FRAME_W + 2);
   localparam int unsigned FAIL_SAT = (1 << FAIL_W) - 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CHECK,
      ST_ARMED,
      ST_LOCKOUT
   } state_t;

   state_t             r_state;
   logic [FRAME_W-1:0] r_shreg;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic [KEY_W-1:0]   r_key_out;
   logic               r_key_valid;
   logic               r_load_done;
   logic               r_load_err;
   logic [FAIL_W-1:0]  r_fail_cnt;
   logic               r_locked;

   logic               w_frame_ok;
   logic [FAIL_W-1:0]  w_fail_inc;
   logic [FRAME_W-1:0] w_shreg_next;
   logic [CNT_W-1:0]   w_bit_cnt_next;
   logic               w_zeroize;

   // Even parity: XOR over the whole frame (key bits + parity bit) is zero.
   assign w_frame_ok     = (r_bit_cnt == CNT_W'(FRAME_W)) && !(^r_shreg);
   assign w_fail_inc     = (r_fail_cnt == FAIL_W'(FAIL_SAT)) ? r_fail_cnt
                                                             : r_fail_cnt + 1'b1;
   // Right shift, new bit at the MSB: after FRAME_W bits the first bit is at [0].
   assign w_shreg_next   = {bus.key_sdi, r_shreg[FRAME_W-1:1]};
   assign w_bit_cnt_next = (r_bit_cnt == CNT_W'(FRAME_W + 1)) ? r_bit_cnt
                                                              : r_bit_cnt + 1'b1;

`ifdef KEY_ZEROIZE_EN
   assign w_zeroize = bus.zeroize && (r_state != ST_LOCKOUT);
`else
   assign w_zeroize = 1'b0;
`endif

   // NOTE: reset is tested inside the clocked block (synchronous), and every
   // state register is updated with <= so all of them see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_shreg     <= '0;
         r_bit_cnt   <= '0;
         r_key_out   <= DECOY;
         r_key_valid <= 1'b0;
         r_load_done <= 1'b0;
         r_load_err  <= 1'b0;
         r_fail_cnt  <= '0;
         r_locked    <= 1'b0;
      end else begin
         // Pulses default low; only CHECK raises them for one cycle.
         r_load_done <= 1'b0;
         r_load_err  <= 1'b0;

         if (w_zeroize) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_key_out   <= DECOY;
            r_key_valid <= 1'b0;
         end else begin
            case (r_state)
               // Load takes priority over shift; the held key in ARMED stays
               // on key_out while a new frame is shifted in.
               ST_IDLE, ST_SHIFT, ST_ARMED: begin
                  if (bus.key_load) begin
                     r_state <= ST_CHECK;
                  end else if (bus.key_sen) begin
                     r_shreg   <= w_shreg_next;
                     r_bit_cnt <= w_bit_cnt_next;
                     r_state   <= ST_SHIFT;
                  end
               end

               ST_CHECK: begin
                  r_shreg   <= '0;
                  r_bit_cnt <= '0;
                  if (w_frame_ok) begin
                     r_key_out   <= r_shreg[KEY_W-1:0];
                     r_key_valid <= 1'b1;
                     r_load_done <= 1'b1;
                     r_state     <= ST_ARMED;
                  end else begin
                     r_key_out   <= DECOY;
                     r_key_valid <= 1'b0;
                     r_load_err  <= 1'b1;
                     r_fail_cnt  <= w_fail_inc;
                     if (w_fail_inc == FAIL_W'(MAX_FAIL)) begin
                        r_state  <= ST_LOCKOUT;
                        r_locked <= 1'b1;
                     end else begin
                        r_state  <= ST_IDLE;
                     end
                  end
               end

               ST_LOCKOUT: begin
                  r_key_out   <= DECOY;
                  r_key_valid <= 1'b0;
                  r_locked    <= 1'b1;
               end

               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.key_out   = r_key_out;
   assign bus.key_valid = r_key_valid;
   assign bus.load_done = r_load_done;
   assign bus.load_err  = r_load_err;
   assign bus.fail_cnt  = r_fail_cnt;
   assign bus.locked    = r_locked;

endmodule

// File: tb/tb_lock_key_loader.sv
// -----------------------------------------------------------------------------
// tb_lock_key_loader
// Directed bench for lock_key_loader. Inputs change 1 ns after a rising edge
// and outputs are sampled at the same point, i.e. after the edge has settled.
// Observed outputs are packed as {key_out, key_valid, load_done, load_err,
// fail_cnt, locked} and compared against hand-computed vectors.
// Define KEY_ZEROIZE_EN to also exercise the zeroize input.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lock_key_loader;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   lock_key_loader_if #(.KEY_W(4), .FAIL_W(2)) bus ();

   lock_key_loader #(
      .KEY_W    (4),
      .DECOY    (4'b0000),
      .MAX_FAIL (3),
      .FAIL_W   (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] outs();
      return {bus.key_out, bus.key_valid, bus.load_done, bus.load_err,
              bus.fail_cnt, bus.locked};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Shift n bits, bits[0] first.
   task automatic shift_bits(input logic [7:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         bus.key_sen = 1'b1;
         bus.key_sdi = bits[i];
         step();
      end
      bus.key_sen = 1'b0;
      bus.key_sdi = 1'b0;
   endtask

   // Pulse key_load; returns once the CHECK result is visible (2 edges).
   task automatic do_load();
      bus.key_load = 1'b1;
      step();
      bus.key_load = 1'b0;
      step();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [9:0] exp;
      rst_n = 1'b0;
      step();
      step();
      exp = {4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL reset_state: got %b expected %b", outs(), exp);
      end
      rst_n = 1'b1;
   endtask

   // T1: frame 0,1,1,0,0 -> key 0110.
   task automatic test_good_commit();
      logic [9:0] exp;
      apply_reset();
      shift_bits(8'b0000_0110, 5);
      exp = {4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t1_no_partial_key: got %b expected %b", outs(), exp);
      end
      bus.key_load = 1'b1;
      step();
      bus.key_load = 1'b0;
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t1_latency_n1: got %b expected %b", outs(), exp);
      end
      step();
      exp = {4'b0110, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t1_commit: got %b expected %b", outs(), exp);
      end
      step();
      exp = {4'b0110, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t1_done_one_cycle: got %b expected %b", outs(), exp);
      end
   endtask

   // T2: frame 0,1,1,0,1 has odd parity. Continues from the ARMED key of T1.
   task automatic test_bad_parity();
      logic [9:0] exp;
      shift_bits(8'b0001_0110, 5);
      do_load();
      exp = {4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t2_parity_err: got %b expected %b", outs(), exp);
      end
      step();
      exp = {4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t2_err_one_cycle: got %b expected %b", outs(), exp);
      end
   endtask

   // T3: three bad frames lock the loader; a good frame is then ignored.
   task automatic test_lockout();
      logic [9:0] exp;
      apply_reset();
      for (int k = 1; k <= 3; k++) begin
         shift_bits(8'b0001_0110, 5);
         do_load();
         exp = {4'b0000, 1'b0, 1'b0, 1'b1, 2'(k), (k == 3) ? 1'b1 : 1'b0};
         n_checks++;
         if (outs() !== exp) begin
            n_errors++;
            $display("FAIL t3_fail_%0d: got %b expected %b", k, outs(), exp);
         end
      end
      shift_bits(8'b0000_0110, 5);
      do_load();
      exp = {4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t3_locked_ignores: got %b expected %b", outs(), exp);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      exp = {4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t3_reset_unlocks: got %b expected %b", outs(), exp);
      end
   endtask

   // T4: short frame, overflowed frame, load wins over a same-cycle shift.
   task automatic test_frame_length();
      logic [9:0] exp;
      apply_reset();
      shift_bits(8'b0000_0110, 3);
      do_load();
      exp = {4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t4_short_frame: got %b expected %b", outs(), exp);
      end
      // Last five of 0,1,1,0,0,0 have even parity, but six bits is an overflow.
      shift_bits(8'b0000_0110, 6);
      do_load();
      exp = {4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t4_long_frame: got %b expected %b", outs(), exp);
      end
      // Four bits in, then load+shift of the fifth (valid) bit together:
      // the shift must be dropped, so the 4-bit frame fails.
      apply_reset();
      shift_bits(8'b0000_0110, 4);
      bus.key_sen  = 1'b1;
      bus.key_sdi  = 1'b0;
      bus.key_load = 1'b1;
      step();
      bus.key_sen  = 1'b0;
      bus.key_load = 1'b0;
      step();
      exp = {4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t4_load_beats_shift: got %b expected %b", outs(), exp);
      end
   endtask

   // T5: reshift while ARMED keeps the old key visible until the commit.
   task automatic test_rearm();
      logic [9:0] exp;
      logic [7:0] frame;
      int         bad;
      apply_reset();
      shift_bits(8'b0000_0110, 5);
      do_load();
      frame = 8'b0000_0101;
      bad   = 0;
      for (int i = 0; i < 5; i++) begin
         bus.key_sen = 1'b1;
         bus.key_sdi = frame[i];
         step();
         if (bus.key_out !== 4'b0110 || bus.key_valid !== 1'b1) bad++;
      end
      bus.key_sen = 1'b0;
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL t5_key_held: got %0d disturbed cycles expected 0", bad);
      end
      do_load();
      exp = {4'b0101, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t5_recommit: got %b expected %b", outs(), exp);
      end
      step();
      do_load();
      exp = {4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t5_empty_reload: got %b expected %b", outs(), exp);
      end
   endtask

   // T6: reset mid-shift clears everything, including the partial frame.
   task automatic test_reset_midshift();
      logic [9:0] exp;
      apply_reset();
      shift_bits(8'b0001_0110, 5);
      do_load();
      shift_bits(8'b0000_0110, 5);
      do_load();
      exp = {4'b0110, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t6_setup: got %b expected %b", outs(), exp);
      end
      shift_bits(8'b0000_0011, 2);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      exp = {4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t6_reset_values: got %b expected %b", outs(), exp);
      end
      // A stale bit count would make this clean frame overflow.
      shift_bits(8'b0000_0101, 5);
      do_load();
      exp = {4'b0101, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL t6_frame_cleared: got %b expected %b", outs(), exp);
      end
   endtask

`ifdef KEY_ZEROIZE_EN
   task automatic test_zeroize();
      logic [9:0] exp;
      apply_reset();
      shift_bits(8'b0001_0110, 5);
      do_load();
      shift_bits(8'b0000_0110, 5);
      do_load();
      step();
      bus.zeroize = 1'b1;
      step();
      bus.zeroize = 1'b0;
      exp = {4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
      n_checks++;
      if (outs() !== exp) begin
         n_errors++;
         $display("FAIL zeroize_armed: got %b expected %b", outs(), exp);
      end
   endtask
`endif

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst_n        = 1'b0;
      bus.key_sen  = 1'b0;
      bus.key_sdi  = 1'b0;
      bus.key_load = 1'b0;
`ifdef KEY_ZEROIZE_EN
      bus.zeroize  = 1'b0;
`endif
      test_reset();
      test_good_commit();
      test_bad_parity();
      test_lockout();
      test_frame_length();
      test_rearm();
      test_reset_midshift();
`ifdef KEY_ZEROIZE_EN
      test_zeroize();
`endif
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
